dma_multi_channel: RTL and testbench

- Parametrised multi-channel DMA controller; the next generation of the single-channel DMA the CPU programs over the shared data bus.
- The CPU writes per-channel source, destination, count and control registers through a slave config port.
- The block requests the bus from the CPU (bus_req/bus_grant), then masters read-then-write word transfers.
- It supports memory-to-memory bursts and peripheral-paced single transfers, arbitrates channels round-robin, and flags completion.

---
 rtl/dma_multi_channel_if.sv | 22 ++
 rtl/dma_multi_channel.sv | 142 ++++++++++++++
 tb/tb_dma_multi_channel.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_multi_channel_if.sv
// dma_multi_channel_if: bus arbitration and word-access signals between the DMA master and memory/CPU side
interface dma_multi_channel_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport master (
    output bus_req, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  bus_grant, mem_rdata, mem_ready
  );
  modport slave (
    input  bus_req, mem_addr, mem_rd, mem_wr, mem_wdata,
    output bus_grant, mem_rdata, mem_ready
  );
endinterface

// File: rtl/dma_multi_channel.sv
// dma_multi_channel: round-robin multi-channel read-then-write DMA with burst and dreq-paced modes.
// Define DMA_IRQ_EN to enable the IE control bit and the irq output; otherwise DONE must be polled.
module dma_multi_channel #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr_i,
  input  logic [$clog2(NUM_CH)+1:0] cfg_addr_i,
  input  logic [DATA_W-1:0]         cfg_wdata_i,
  output logic [DATA_W-1:0]         cfg_rdata_o,
  input  logic [NUM_CH-1:0]         dreq_i,
  output logic [NUM_CH-1:0]         dack_o,
  output logic                      irq_o,
  dma_multi_channel_if.master       bus
);
  localparam int CH_W = $clog2(NUM_CH);
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, UPD} state_t;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, rr_q, rr_d, sel;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] src_q [NUM_CH];
  logic [ADDR_W-1:0] src_d [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH];
  logic [ADDR_W-1:0] dst_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [5:0]        ctrl_q [NUM_CH];
  logic [5:0]        ctrl_d [NUM_CH];
  logic [NUM_CH-1:0] elig, served;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_reg;
  logic [CNT_W-1:0]  cnt_n;
  logic              ie_w;
  assign cfg_ch  = cfg_addr_i[CH_W+1:2];
  assign cfg_reg = cfg_addr_i[1:0];
  assign cnt_n   = cnt_q[ch_q] == '0 ? '0 : cnt_q[ch_q] - CNT_W'(1);
  assign cfg_rdata_o = cfg_reg == 2'd0 ? DATA_W'(src_q[cfg_ch]) :
                       cfg_reg == 2'd1 ? DATA_W'(dst_q[cfg_ch]) :
                       cfg_reg == 2'd2 ? DATA_W'(cnt_q[cfg_ch]) : DATA_W'(ctrl_q[cfg_ch]);
`ifdef DMA_IRQ_EN
  logic [NUM_CH-1:0] done_ie;
  assign ie_w = cfg_wdata_i[5];
  always_comb
    for (int c = 0; c < NUM_CH; c++) done_ie[c] = ctrl_q[c][4] & ctrl_q[c][5];
  assign irq_o = |done_ie;
`else
  assign ie_w  = 1'b0;
  assign irq_o = 1'b0;
`endif
  always_comb
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c]   = ctrl_q[c][0] && cnt_q[c] != '0 && (ctrl_q[c][1] || dreq_i[c]);
      served[c] = state_q != IDLE && ch_q == CH_W'(c);
    end
  // Scan downward so the closest eligible channel at or after rr wins.
  always_comb begin
    sel = rr_q;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (elig[rr_q + CH_W'(i)]) sel = rr_q + CH_W'(i);
  end
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (|elig) begin
        ch_d    = sel;
        state_d = REQ;
      end
      REQ: state_d = !ctrl_q[ch_q][0] ? IDLE : bus.bus_grant ? RD : REQ;
      RD: if (bus.mem_ready) begin
        buf_d   = bus.mem_rdata;
        state_d = WR;
      end
      WR: state_d = bus.mem_ready ? UPD : WR;
      UPD: if (!ctrl_q[ch_q][0] || cnt_n == '0 || !ctrl_q[ch_q][1]) begin
        state_d = IDLE;
        rr_d    = ch_q + CH_W'(1);
      end else state_d = bus.bus_grant ? RD : REQ;
      default: state_d = IDLE;
    endcase
  end
  // Hardware updates come after config writes so a DONE set beats a same-cycle W1C.
  always_comb
    for (int c = 0; c < NUM_CH; c++) begin
      src_d[c]  = src_q[c];
      dst_d[c]  = dst_q[c];
      cnt_d[c]  = cnt_q[c];
      ctrl_d[c] = ctrl_q[c];
      if (cfg_wr_i && cfg_ch == CH_W'(c)) begin
        if (cfg_reg == 2'd0 && !served[c]) src_d[c] = ADDR_W'(cfg_wdata_i);
        if (cfg_reg == 2'd1 && !served[c]) dst_d[c] = ADDR_W'(cfg_wdata_i);
        if (cfg_reg == 2'd2 && !served[c]) cnt_d[c] = CNT_W'(cfg_wdata_i);
        if (cfg_reg == 2'd3) ctrl_d[c] = {ie_w, ctrl_q[c][4] & ~cfg_wdata_i[4], cfg_wdata_i[3:0]};
      end
      if (state_q == UPD && ch_q == CH_W'(c)) begin
        cnt_d[c] = cnt_n;
        if (ctrl_q[c][2]) src_d[c] = src_q[c] + ADDR_W'(ADDR_STEP);
        if (ctrl_q[c][3]) dst_d[c] = dst_q[c] + ADDR_W'(ADDR_STEP);
        if (ctrl_q[c][0] && cnt_n == '0) begin
          ctrl_d[c][4] = 1'b1;
          ctrl_d[c][0] = 1'b0;
        end
      end
      if (ctrl_q[c][0] && cnt_q[c] == '0 && !served[c]) begin
        ctrl_d[c][4] = 1'b1;
        ctrl_d[c][0] = 1'b0;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rr_q    <= '0;
      buf_q   <= '0;
      src_q   <= '{default: '0};
      dst_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      ctrl_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      buf_q   <= buf_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  assign bus.bus_req   = state_q != IDLE;
  assign bus.mem_rd    = state_q == RD;
  assign bus.mem_wr    = state_q == WR;
  assign bus.mem_addr  = state_q == RD ? src_q[ch_q] : state_q == WR ? dst_q[ch_q] : '0;
  assign bus.mem_wdata = state_q == WR ? buf_q : '0;
  assign dack_o        = (state_q == UPD && !ctrl_q[ch_q][1]) ? NUM_CH'(1) << ch_q : '0;
endmodule

// File: tb/tb_dma_multi_channel.sv
// tb_dma_multi_channel: scoreboard bench; expected bus accesses are queued at stimulus time and popped by a monitor.
module tb_dma_multi_channel;
`ifdef DMA_IRQ_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif
  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0, cfg_rdata;
  logic [1:0]  dreq = '0, dack;
  logic        irq, grant = 1'b1, ready_en = 1'b1;
  int          checks = 0, errors = 0, d0 = 0, d1 = 0;
  txn_t        exp_q[$];
  dma_multi_channel_if bus();
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction
  assign bus.bus_grant = grant;
  assign bus.mem_ready = (bus.mem_rd | bus.mem_wr) & ready_en;
  assign bus.mem_rdata = bus.mem_rd ? mem_val(bus.mem_addr) : '0;
  always #5 clk = ~clk;
  dma_multi_channel dut (
    .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rdata_o(cfg_rdata), .dreq_i(dreq), .dack_o(dack), .irq_o(irq), .bus(bus)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask
  task automatic push_word(input logic [31:0] src, input logic [31:0] dst);
    exp_q.push_back({1'b0, src, mem_val(src)});
    exp_q.push_back({1'b1, dst, mem_val(src)});
  endtask
  task automatic observe(input logic wr, input logic [31:0] a, input logic [31:0] d);
    txn_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_access: got wr=%0d addr %h required no access", wr, a);
    end else begin
      e = exp_q.pop_front();
      check("access_kind", {31'b0, wr}, {31'b0, e.wr});
      check(wr ? "wr_addr" : "rd_addr", a, e.addr);
      if (wr) check("wr_data", d, e.data);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.mem_rd && bus.mem_ready) observe(1'b0, bus.mem_addr, bus.mem_rdata);
      if (bus.mem_wr && bus.mem_ready) observe(1'b1, bus.mem_addr, bus.mem_wdata);
      d0 += int'(dack[0]);
      d1 += int'(dack[1]);
    end
  task automatic cfg_write(input int ch, input int rg, input logic [31:0] d);
    @(posedge clk);
    #1;
    cfg_wr    = 1'b1;
    cfg_addr  = 3'(ch * 4 + rg);
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask
  task automatic rd_reg(input int ch, input int rg, output logic [31:0] v);
    cfg_addr = 3'(ch * 4 + rg);
    #1;
    v = cfg_rdata;
  endtask
  task automatic wait_done(input int ch, input int budget, input string name, output int n);
    logic [31:0] v;
    n = 0;
    rd_reg(ch, 3, v);
    while (!v[4] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      rd_reg(ch, 3, v);
    end
    if (!v[4]) expire(name);
  endtask
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] v;
    int n, b0, b1;
    step(3);
    check("rst_bus_req", 32'(bus.bus_req), 0);
    check("rst_mem_rd", 32'(bus.mem_rd), 0);
    check("rst_mem_wr", 32'(bus.mem_wr), 0);
    check("rst_dack", 32'(dack), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++) begin
        rd_reg(c, r, v);
        check("rst_reg", v, 0);
      end
    // memory-to-memory burst of three words
    push_word(32'h100, 32'h200);
    push_word(32'h104, 32'h204);
    push_word(32'h108, 32'h208);
    cfg_write(0, 0, 32'h100);
    cfg_write(0, 1, 32'h200);
    cfg_write(0, 2, 3);
    cfg_write(0, 3, 32'h0F);
    wait_done(0, 50, "mtm_done", n);
    check("mtm_latency", n, 11);
    check("mtm_bus_req_drop", 32'(bus.bus_req), 0);
    rd_reg(0, 2, v); check("mtm_cnt", v, 0);
    rd_reg(0, 3, v); check("mtm_ctrl", v, 32'h1E);
    rd_reg(0, 0, v); check("mtm_src", v, 32'h10C);
    rd_reg(0, 1, v); check("mtm_dst", v, 32'h20C);
    check("mtm_irq", 32'(irq), 0);
    cfg_write(0, 3, 32'h10);
    rd_reg(0, 3, v); check("w1c_ctrl", v, 0);
    // zero count completes without bus traffic
    cfg_write(1, 3, 32'h23);
    step(2);
    rd_reg(1, 3, v); check("zero_ctrl", v, IE ? 32'h32 : 32'h12);
    check("zero_irq", 32'(irq), {31'b0, IE});
    check("zero_bus_req", 32'(bus.bus_req), 0);
    cfg_write(1, 3, 32'h10);
    rd_reg(1, 3, v); check("zero_w1c", v, 0);
    check("zero_irq_clr", 32'(irq), 0);
    // dreq-paced, fixed destination
    push_word(32'h300, 32'h400);
    push_word(32'h304, 32'h400);
    cfg_write(1, 0, 32'h300);
    cfg_write(1, 1, 32'h400);
    cfg_write(1, 2, 2);
    cfg_write(1, 3, 32'h05);
    b1 = d1;
    step(3);
    check("paced_no_dreq_idle", 32'(bus.bus_req), 0);
    @(posedge clk); #1; dreq = 2'b10;
    @(posedge clk); #1; dreq = 2'b00;
    n = 0;
    while (d1 == b1 && n < 20) begin step(1); n++; end
    if (d1 == b1) expire("paced_dack1");
    check("paced_gap_bus_req", 32'(bus.bus_req), 0);
    step(3);
    check("paced_gap_hold", 32'(bus.bus_req), 0);
    rd_reg(1, 2, v); check("paced_cnt_mid", v, 1);
    @(posedge clk); #1; dreq = 2'b10;
    @(posedge clk); #1; dreq = 2'b00;
    wait_done(1, 30, "paced_done", n);
    check("paced_dack_count", d1 - b1, 2);
    rd_reg(1, 1, v); check("paced_dst_fixed", v, 32'h400);
    rd_reg(1, 0, v); check("paced_src", v, 32'h308);
    cfg_write(1, 3, 32'h10);
    // round-robin contention, both channels raised in the same cycle
    push_word(32'h500, 32'h600);
    push_word(32'h700, 32'h800);
    push_word(32'h504, 32'h604);
    push_word(32'h704, 32'h804);
    cfg_write(0, 0, 32'h500);
    cfg_write(0, 1, 32'h600);
    cfg_write(0, 2, 2);
    cfg_write(0, 3, 32'h0D);
    cfg_write(1, 0, 32'h700);
    cfg_write(1, 1, 32'h800);
    cfg_write(1, 2, 2);
    cfg_write(1, 3, 32'h0D);
    b0 = d0;
    b1 = d1;
    @(posedge clk); #1; dreq = 2'b11;
    wait_done(1, 80, "rr_done", n);
    dreq = 2'b00;
    rd_reg(0, 3, v); check("rr_ch0_ctrl", v, 32'h1C);
    check("rr_dack0", d0 - b0, 2);
    check("rr_dack1", d1 - b1, 2);
    cfg_write(0, 3, 32'h10);
    cfg_write(1, 3, 32'h10);
    // grant loss in the read of word 2
    push_word(32'h900, 32'hA00);
    push_word(32'h904, 32'hA04);
    push_word(32'h908, 32'hA08);
    push_word(32'h90C, 32'hA0C);
    cfg_write(0, 0, 32'h900);
    cfg_write(0, 1, 32'hA00);
    cfg_write(0, 2, 4);
    cfg_write(0, 3, 32'h0F);
    n = 0;
    while (!(bus.mem_rd && bus.mem_addr == 32'h904) && n < 30) begin step(1); n++; end
    if (!(bus.mem_rd && bus.mem_addr == 32'h904)) expire("gl_word2_rd");
    grant = 1'b0;
    step(5);
    check("gl_bus_req_held", 32'(bus.bus_req), 1);
    check("gl_no_rd", 32'(bus.mem_rd), 0);
    check("gl_no_wr", 32'(bus.mem_wr), 0);
    rd_reg(0, 2, v); check("gl_cnt", v, 2);
    rd_reg(0, 0, v); check("gl_src", v, 32'h908);
    grant = 1'b1;
    wait_done(0, 40, "gl_done", n);
    rd_reg(0, 0, v); check("gl_src_end", v, 32'h910);
    rd_reg(0, 1, v); check("gl_dst_end", v, 32'hA10);
    // asynchronous reset while a write is stalled
    exp_q.push_back({1'b0, 32'hB00, mem_val(32'hB00)});
    cfg_write(1, 0, 32'hB00);
    cfg_write(1, 1, 32'hC00);
    cfg_write(1, 2, 2);
    cfg_write(1, 3, 32'h0F);
    n = 0;
    while (!bus.mem_wr && n < 20) begin step(1); n++; end
    if (!bus.mem_wr) expire("rst_wait_wr");
    ready_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_mem_wr", 32'(bus.mem_wr), 0);
    check("arst_bus_req", 32'(bus.bus_req), 0);
    check("arst_irq", 32'(irq), 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    rd_reg(0, 3, v); check("arst_ctrl0", v, 0);
    rd_reg(1, 3, v); check("arst_ctrl1", v, 0);
    rd_reg(1, 2, v); check("arst_cnt1", v, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
